// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared definitions for the RV32M multiply/divide unit.
//   - funct3 encodings of the eight M-extension ops
//   - FSM state enum used by muldiv_unit
//   - is_div(): true for DIV/DIVU/REM/REMU
package rv32m_pkg;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_SPECIAL,
        S_FIX,
        S_DONE
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: issue/result handshake between the execute stage and the
// multiply/divide unit.
//   master (execute stage): drives start, funct3, a, b; sees ready, done, result
//   slave  (muldiv_unit)  : the reverse
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            ready;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, a, b,
        input  ready, done, result
    );

    modport slave (
        input  start, funct3, a, b,
        output ready, done, result
    );
endinterface

// File: rtl/muldiv_div_core.sv
// muldiv_div_core: one step of a restoring divider (combinational).
//   divisor  in  XLEN    divisor magnitude
//   rem      in  XLEN+1  current partial remainder
//   quot     in  XLEN    dividend bits still to shift in / quotient bits so far
//   rem_nxt  out XLEN+1  partial remainder after this step
//   quot_nxt out XLEN    quot shifted left with the new quotient bit in bit 0
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] divisor,
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quot,
    output logic [XLEN:0]   rem_nxt,
    output logic [XLEN-1:0] quot_nxt
);
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;
    logic            q_bit;

    // Trial subtraction one bit wider than the remainder so the borrow is
    // visible in the top bit; a borrow means "restore" (keep shifted value).
    always_comb begin
        shifted  = {rem, quot[XLEN-1]};
        diff     = shifted - {2'b00, divisor};
        q_bit    = ~diff[XLEN+1];
        rem_nxt  = q_bit ? diff[XLEN:0] : shifted[XLEN:0];
        quot_nxt = {quot[XLEN-2:0], q_bit};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit.
//   clk  in  clock, all state on rising edge
//   rst  in  synchronous active-high reset (aborts any op in flight)
//   bus  slave side of muldiv_unit_if (start/funct3/a/b in; ready/done/result out)
// Operands are reduced to magnitudes at accept; an unsigned shift-add
// multiplier or a restoring divider runs XLEN iterations, then FIX applies
// the sign and selects the output word. Divide-by-zero and signed overflow
// are resolved at accept without iterating.
// Build option: define FAST_MUL_EN to replace the iterative multiplier with a
// single-cycle combinational multiplier (divide path unchanged).
module muldiv_unit
    import rv32m_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);

    state_t          state, state_nxt;
    logic [2:0]      op;
    logic            neg;
    logic [XLEN-1:0] abs_b;
    logic [CW-1:0]   counter;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] quot;
    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quot_nxt;
    logic [XLEN-1:0] result;

    // ---------------- accept-time decode (from bus inputs) ----------------
    logic            accept;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            neg_in, div0, ovf, special;
    logic [XLEN-1:0] special_res;

    assign accept = bus.start & bus.ready;

    always_comb begin
        a_signed = (bus.funct3 == MUL) || (bus.funct3 == MULH) || (bus.funct3 == MULHSU)
                || (bus.funct3 == DIV) || (bus.funct3 == REM);
        b_signed = (bus.funct3 == MUL) || (bus.funct3 == MULH)
                || (bus.funct3 == DIV) || (bus.funct3 == REM);
        a_neg    = a_signed & bus.a[XLEN-1];
        b_neg    = b_signed & bus.b[XLEN-1];
        a_abs    = a_neg ? -bus.a : bus.a;
        b_abs    = b_neg ? -bus.b : bus.b;
        // Remainder follows the dividend's sign; everything else the product sign.
        neg_in   = (is_div(bus.funct3) && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div0     = is_div(bus.funct3) && (bus.b == '0);
        ovf      = ((bus.funct3 == DIV) || (bus.funct3 == REM))
                && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);
        special  = div0 | ovf;
        if (div0)
            special_res = bus.funct3[1] ? bus.a : '1;
        else
            special_res = bus.funct3[1] ? '0 : bus.a;
    end

    // ---------------- multiplier datapath ----------------
`ifdef FAST_MUL_EN
    logic signed [XLEN:0]     fast_opa, fast_opb;
    logic signed [2*XLEN+1:0] fast_prod;
    logic [XLEN-1:0]          fast_res;

    always_comb begin
        fast_opa  = $signed({a_signed & bus.a[XLEN-1], bus.a});
        fast_opb  = $signed({b_signed & bus.b[XLEN-1], bus.b});
        fast_prod = fast_opa * fast_opb;
        fast_res  = (bus.funct3 == MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`else
    // Upper half accumulates; lower half starts as the multiplier and is
    // consumed LSB-first as the product shifts right.
    logic [2*XLEN-1:0] prod, prod_nxt, prod_s;
    logic [XLEN:0]     mul_sum;

    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, abs_b} : '0);
        prod_nxt = {mul_sum, prod[XLEN-1:1]};
        prod_s   = neg ? -prod : prod;
    end
`endif

    // ---------------- divider step ----------------
    muldiv_div_core #(.XLEN(XLEN)) u_div (
        .divisor  (abs_b),
        .rem      (rem),
        .quot     (quot),
        .rem_nxt  (rem_nxt),
        .quot_nxt (quot_nxt)
    );

    // ---------------- FIX result select ----------------
    logic [XLEN-1:0] q_s, r_s, fix_res;

    always_comb begin
        q_s = neg ? -quot : quot;
        r_s = neg ? -rem[XLEN-1:0] : rem[XLEN-1:0];
`ifdef FAST_MUL_EN
        fix_res = op[1] ? r_s : q_s;
`else
        if (is_div(op))
            fix_res = op[1] ? r_s : q_s;
        else
            fix_res = (op == MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`endif
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (special)                  state_nxt = S_SPECIAL;
                    else if (is_div(bus.funct3))  state_nxt = S_DIV;
`ifdef FAST_MUL_EN
                    else                          state_nxt = S_SPECIAL;
`else
                    else                          state_nxt = S_MUL;
`endif
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: if (counter == CW'(1)) state_nxt = S_FIX;
            S_FIX, S_SPECIAL: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op      <= '0;
            neg     <= 1'b0;
            abs_b   <= '0;
            counter <= '0;
            rem     <= '0;
            quot    <= '0;
            result  <= '0;
`ifndef FAST_MUL_EN
            prod    <= '0;
`endif
        end else if (accept) begin
            op      <= bus.funct3;
            neg     <= neg_in;
            abs_b   <= b_abs;
            counter <= CW'(XLEN);
            rem     <= '0;
            quot    <= a_abs;
`ifdef FAST_MUL_EN
            if (special)                    result <= special_res;
            else if (!is_div(bus.funct3))   result <= fast_res;
`else
            prod    <= {{XLEN{1'b0}}, a_abs};
            if (special)                    result <= special_res;
`endif
        end else begin
            case (state)
`ifndef FAST_MUL_EN
                S_MUL: begin
                    prod    <= prod_nxt;
                    counter <= counter - CW'(1);
                end
`endif
                S_DIV: begin
                    rem     <= rem_nxt;
                    quot    <= quot_nxt;
                    counter <= counter - CW'(1);
                end
                S_FIX:   result <= fix_res;
                default: ;
            endcase
        end
    end

    assign bus.ready  = (state == S_IDLE) || (state == S_DONE);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized + directed bench for muldiv_unit with an
// arithmetic reference model (64-bit integer math) and a scoreboard queue.
module tb_muldiv_unit;
    import rv32m_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          c0;
        int          lat;
        logic [31:0] exp;
    } op_t;

    op_t         pend[$];
    int          cyc    = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last   = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic plus the RISC-V corner-case rules.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, ps;
        longint unsigned ux, uy, pu;
        logic            ovf;
        logic [31:0]     r;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'h0, x};
        uy  = {32'h0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            MUL:    begin ps = sx * sy;           r = ps[31:0];  end
            MULH:   begin ps = sx * sy;           r = ps[63:32]; end
            MULHSU: begin ps = sx * longint'(uy); r = ps[63:32]; end
            MULHU:  begin pu = ux * uy;           r = pu[63:32]; end
            DIV:    if (y == 0) r = '1; else if (ovf) r = x; else begin ps = sx / sy; r = ps[31:0]; end
            DIVU:   if (y == 0) r = '1; else r = x / y;
            REM:    if (y == 0) r = x;  else if (ovf) r = '0; else begin ps = sx % sy; r = ps[31:0]; end
            default: if (y == 0) r = x; else r = x % y;
        endcase
        return r;
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic sp;
        sp = f[2] && ((y == 0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
        if (sp) return 1;
`ifdef FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    // Must be called just after a negedge; returns just after the negedge following acceptance.
    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        op_t e;
        int  n = 0;
        while (!bus.ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!bus.ready) begin
            errors++;
            $display("FAIL issue_wait: ready got 0, expected 1 (cycle %0d)", cyc);
            return;
        end
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.a      = x;
        bus.b      = y;
        e.f = f; e.a = x; e.b = y;
        e.c0  = cyc + 1;
        e.lat = latency(f, x, y);
        e.exp = model(f, x, y);
        pend.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Scoreboard/compare process.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (pend.size() == 0) begin
                    chk("spurious_done", 32'(bus.done), 32'd0);
                end else begin
                    op_t e;
                    e = pend.pop_front();
                    chk($sformatf("result f3=%0d a=%h b=%h", e.f, e.a, e.b), bus.result, e.exp);
                    chk("latency", 32'(cyc - e.c0), 32'(e.lat));
                    chk("ready_in_done", 32'(bus.ready), 32'd1);
                    last = e.exp;
                end
            end else if (pend.size() == 0) begin
                chk("result_hold", bus.result, last);
            end else if (cyc > pend[0].c0 + 40) begin
                chk("done_timeout", 32'(bus.done), 32'd1);
                void'(pend.pop_front());
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.a      = '0;
        bus.b      = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ready",  32'(bus.ready), 32'd1);
        chk("reset_done",   32'(bus.done),  32'd0);
        chk("reset_result", bus.result,     32'd0);
        rst = 1'b0;

        // Pin the model with hand-computed values
        chk("model_mul",    model(MUL,    32'd7,         32'hFFFF_FFFD), 32'hFFFF_FFEB);
        chk("model_mulh",   model(MULH,   32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("model_mulhu",  model(MULHU,  32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        chk("model_mulhsu", model(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        chk("model_div",    model(DIV,    32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFD);
        chk("model_rem",    model(REM,    32'hFFFF_FFF9, 32'd2),         32'hFFFF_FFFF);
        chk("model_divu",   model(DIVU,   32'hFFFF_FFFF, 32'd16),        32'h0FFF_FFFF);
        chk("model_div0",   model(DIV,    32'd123,       32'd0),         32'hFFFF_FFFF);
        chk("model_rem0",   model(REM,    32'd123,       32'd0),         32'd123);
        chk("model_ovf_d",  model(DIV,    32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("model_ovf_r",  model(REM,    32'h8000_0000, 32'hFFFF_FFFF), 32'd0);

        // Directed ops through the DUT (back-to-back where issued consecutively)
        issue(MUL,    32'd7,         32'hFFFF_FFFD);
        issue(MULH,   32'h8000_0000, 32'h8000_0000);
        issue(MULHU,  32'h8000_0000, 32'h8000_0000);
        issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(DIV,    32'hFFFF_FFF9, 32'd2);
        issue(REM,    32'hFFFF_FFF9, 32'd2);
        issue(DIVU,   32'hFFFF_FFFF, 32'd16);
        issue(DIV,    32'd123,       32'd0);
        issue(REM,    32'd123,       32'd0);
        issue(DIV,    32'h8000_0000, 32'hFFFF_FFFF);
        issue(REM,    32'h8000_0000, 32'hFFFF_FFFF);

        // start while busy must be ignored
        issue(MUL, 32'd1000, 32'd3);
        bus.start = 1'b1; bus.funct3 = DIVU; bus.a = 32'd55; bus.b = 32'd5;
        repeat (3) @(negedge clk);
        chk("busy_ready", 32'(bus.ready), 32'd0);
        bus.start = 1'b0;

        // Reset in the middle of a divide
        issue(DIV, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        pend.delete();
        last = '0;
        @(negedge clk);
        chk("midrst_ready",  32'(bus.ready), 32'd1);
        chk("midrst_done",   32'(bus.done),  32'd0);
        chk("midrst_result", bus.result,     32'd0);
        rst = 1'b0;
        issue(REMU, 32'd100, 32'd7);

        // Randomized ops with random gaps
        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain
        for (int i = 0; i < 100 && pend.size() > 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("drained", 32'(pend.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
